ft_fault_injector: RTL

Verification-side fault injector that drives the triplicated instruction inputs of the fault-tolerant decoder blocks: it takes one clean instruction stream and fans it out to three lanes, corrupting one chosen lane with a programmable XOR mask for a programmed window of instructions. It also drives `set_broken` into a block's breakage monitors and observes their `is_broken` outputs to report whether the campaign was detected. It sits between the fetch-side instruction source and any `*_ft` block built with triplicated input.

---
 rtl/ft_fault_injector_pkg.sv | 25 ++
 rtl/ft_fi_lfsr.sv | 34 +++
 rtl/ft_fault_injector.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ft_fault_injector_pkg.sv
// Shared types and constants for the fault injector: FSM states, LFSR polynomial
// and lane encoding helpers.
package ft_fault_injector_pkg;

  typedef enum logic [1:0] {
    FI_IDLE   = 2'd0,
    FI_WAIT   = 2'd1,
    FI_INJECT = 2'd2,
    FI_DONE   = 2'd3
  } fi_state_e;

  localparam logic [7:0] FI_LFSR_POLY    = 8'hB8;
  localparam logic [1:0] FI_LANE_ILLEGAL = 2'd3;

  // One-hot lane select; the illegal lane code maps to no lane at all.
  function automatic logic [2:0] fi_lane_onehot(input logic [1:0] lane);
    logic [2:0] onehot;
    onehot = 3'b000;
    if (lane != FI_LANE_ILLEGAL) begin
      onehot[lane] = 1'b1;
    end
    return onehot;
  endfunction

endpackage

// File: rtl/ft_fi_lfsr.sv
// 8-bit right-shifting Galois LFSR used to pick a random bit when a campaign
// arrives with an all-zero mask. A nonzero seed keeps it out of the lock-up state.
module ft_fi_lfsr
  import ft_fault_injector_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] value
);

  logic [7:0] value_reg;
  logic [7:0] value_next;

  always_comb begin
    value_next = value_reg;
    if (en) begin
      value_next = value_reg[0] ? ((value_reg >> 1) ^ FI_LFSR_POLY) : (value_reg >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= SEED;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/ft_fault_injector.sv
// Fans a clean instruction out to three lanes and corrupts one lane with an XOR
// mask for a programmed window of valid instructions; reports breakage detection.
module ft_fault_injector
  import ft_fault_injector_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter int         DELAY_W   = 8,
  parameter int         DUR_W     = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        instr_i,
  input  logic                    instr_valid_i,
  output logic [2:0][WIDTH-1:0]   instr_o,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [1:0]              cmd_lane_i,
  input  logic [WIDTH-1:0]        cmd_mask_i,
  input  logic [DELAY_W-1:0]      cmd_delay_i,
  input  logic [DUR_W-1:0]        cmd_dur_i,
  input  logic                    cmd_set_broken_i,
  input  logic                    abort_i,
  output logic [2:0]              set_broken_o,
  input  logic [2:0]              is_broken_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    detected_o,
  output logic                    cmd_err_o
);

  fi_state_e          state_reg, state_next;
  logic [7:0]         lfsr;
  logic               accept;
  logic               lane_legal;
  logic [WIDTH-1:0]   rand_mask;
  logic [WIDTH-1:0]   mask_next;
  logic [2:0]         lane_onehot;
  logic               lane_broken;
  logic               busy;

  logic [1:0]         lane_reg;
  logic [WIDTH-1:0]   mask_reg;
  logic [DELAY_W-1:0] delay_reg;
  logic [DUR_W-1:0]   dur_reg;
  logic               sticky_reg;
  logic               set_broken_reg;
  logic               first_inject_reg;
  logic               detected_reg;
  logic               cmd_err_reg;

  ft_fi_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .value (lfsr)
  );

  assign accept      = cmd_valid_i & cmd_ready_o;
  assign lane_legal  = (cmd_lane_i != FI_LANE_ILLEGAL);
  assign lane_onehot = fi_lane_onehot(lane_reg);
  assign lane_broken = |(is_broken_i & lane_onehot);
  assign busy        = (state_reg != FI_IDLE);

  // Random single-bit mask is taken from the LFSR value present in the accept cycle.
  always_comb begin
    rand_mask = {{(WIDTH-1){1'b0}}, 1'b1} << (32'(lfsr) % 32'(WIDTH));
    mask_next = (cmd_mask_i == '0) ? rand_mask : cmd_mask_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FI_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FI_IDLE: begin
        if (accept && lane_legal) begin
          state_next = (cmd_delay_i != '0) ? FI_WAIT : FI_INJECT;
        end
      end
      FI_WAIT: begin
        if (abort_i) begin
          state_next = FI_IDLE;
        end else if (instr_valid_i && (delay_reg == DELAY_W'(1))) begin
          state_next = FI_INJECT;
        end
      end
      FI_INJECT: begin
        if (abort_i) begin
          state_next = FI_IDLE;
        end else if (!sticky_reg && instr_valid_i && (dur_reg == DUR_W'(1))) begin
          state_next = FI_DONE;
        end
      end
      FI_DONE: begin
        state_next = FI_IDLE;
      end
      default: begin
        state_next = FI_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_reg         <= 2'd0;
      mask_reg         <= '0;
      delay_reg        <= '0;
      dur_reg          <= '0;
      sticky_reg       <= 1'b0;
      set_broken_reg   <= 1'b0;
      first_inject_reg <= 1'b0;
      detected_reg     <= 1'b0;
      cmd_err_reg      <= 1'b0;
    end else begin
      cmd_err_reg      <= accept && !lane_legal;
      first_inject_reg <= (state_next == FI_INJECT) && (state_reg != FI_INJECT);
      if (accept) begin
        detected_reg <= 1'b0;
        // A rejected command leaves the previous campaign settings in place.
        if (lane_legal) begin
          lane_reg       <= cmd_lane_i;
          mask_reg       <= mask_next;
          delay_reg      <= cmd_delay_i;
          dur_reg        <= cmd_dur_i;
          sticky_reg     <= (cmd_dur_i == '0);
          set_broken_reg <= cmd_set_broken_i;
        end
      end else begin
        if (busy && lane_broken) begin
          detected_reg <= 1'b1;
        end
        if ((state_reg == FI_WAIT) && instr_valid_i && (delay_reg != '0)) begin
          delay_reg <= delay_reg - DELAY_W'(1);
        end
        if ((state_reg == FI_INJECT) && instr_valid_i && !sticky_reg && (dur_reg != '0)) begin
          dur_reg <= dur_reg - DUR_W'(1);
        end
      end
    end
  end

  always_comb begin
    busy_o       = busy;
    done_o       = (state_reg == FI_DONE);
    cmd_ready_o  = (state_reg == FI_IDLE) && !abort_i;
    cmd_err_o    = cmd_err_reg;
    set_broken_o = 3'b000;
    if ((state_reg == FI_INJECT) && first_inject_reg && set_broken_reg) begin
      set_broken_o = lane_onehot;
    end
    // Breakage seen this cycle is reported immediately, not one cycle late.
    detected_o   = detected_reg | (busy & lane_broken);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign instr_o[gi] = ((state_reg == FI_INJECT) && (lane_reg == 2'(gi)))
                           ? (instr_i ^ mask_reg) : instr_i;
    end
  endgenerate

endmodule
